camac_dataway_receiver: RTL

Receive-side counterpart to the SN74LS365/366-style tri-state dataway drivers on the ISA–CAMAC interface board. It samples an active-low dataway word qualified by a bus strobe, synchronises and deglitches it, and latches the word into a single-entry output register. Captured words are handed to the ISA-side logic over a valid/ready handshake. It has the same two-enable gating as the driver: the block receives only while both enables are low.

---
 rtl/camac_dataway_receiver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/camac_dataway_receiver.sv
// CAMAC dataway receiver: synchronises, deglitches and latches one strobed word into a valid/ready output register.
// Latency: SETTLE at edge 3 after strobe, capture FILTER_LEN edges later; a full buffer drops the new word and sets overrun.
module camac_dataway_receiver #(
   parameter int WIDTH          = 6,
   parameter bit INVERTED_INPUT = 1'b1,
   parameter int FILTER_LEN     = 3,
   parameter int TIMEOUT        = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             e1,
   input  logic             e2,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             strobe_n,
   output logic [WIDTH-1:0] data_out,
   output logic             valid,
   input  logic             ready,
   output logic             busy,
   output logic             overrun,
   output logic             timeout_err,
   input  logic             clr_flags
);

   localparam logic [3:0]  STABLE_LAST  = 4'(FILTER_LEN - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] bus_m, bus_s, bus_prev;
   logic             strb_m, strb_s;
   logic [3:0]       stable_cnt, stable_nxt;
   logic [15:0]      tmo_cnt, tmo_nxt;
   logic             en, match, capture, tmo_hit, load, drop;
   logic [WIDTH-1:0] word;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_m    <= '0;
         bus_s    <= '0;
         bus_prev <= '0;
         strb_m   <= 1'b1;
         strb_s   <= 1'b1;
      end else begin
         bus_m    <= bus_in;
         bus_s    <= bus_m;
         bus_prev <= bus_s;
         strb_m   <= strobe_n;
         strb_s   <= strb_m;
      end
   end

   assign en    = ~e1 & ~e2;
   assign match = (bus_s == bus_prev);
   assign word  = INVERTED_INPUT ? ~bus_s : bus_s;
   assign busy  = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      stable_nxt = stable_cnt;
      tmo_nxt    = tmo_cnt;
      capture    = 1'b0;
      tmo_hit    = 1'b0;
      case (state)
         IDLE: begin
            if (en && !strb_s) begin
               state_nxt  = SETTLE;
               stable_nxt = '0;
               tmo_nxt    = '0;
            end
         end
         SETTLE: begin
            if (match)
               stable_nxt = (stable_cnt == 4'hF) ? stable_cnt : stable_cnt + 4'd1;
            else
               stable_nxt = '0;
            tmo_nxt = tmo_cnt + 16'd1;
            // Abort outranks capture, which outranks timeout.
            if (!en || strb_s) begin
               state_nxt = IDLE;
            end else if (match && (stable_cnt == STABLE_LAST)) begin
               capture   = 1'b1;
               state_nxt = HOLD;
            end else if (tmo_cnt == TIMEOUT_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (strb_s || !en)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign load = capture && (!valid || ready);
   assign drop = capture && valid && !ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         stable_cnt  <= '0;
         tmo_cnt     <= '0;
         data_out    <= '0;
         valid       <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state      <= state_nxt;
         stable_cnt <= stable_nxt;
         tmo_cnt    <= tmo_nxt;
         if (load) begin
            data_out <= word;
            valid    <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
         // Set beats clear when both land on the same edge.
         if (drop)
            overrun <= 1'b1;
         else if (clr_flags)
            overrun <= 1'b0;
         if (tmo_hit)
            timeout_err <= 1'b1;
         else if (clr_flags)
            timeout_err <= 1'b0;
      end
   end

endmodule
